// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the logic-unit arbiter: opcodes and FSM encodings.
package lu_pkg;

   localparam logic [1:0] OP_NOT = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_OR  = 2'd2;
   localparam logic [1:0] OP_XOR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } lu_state_e;

endpackage

// File: rtl/logic_unit_arbiter_rr_pick.sv
// Combinational winner selection for the logic-unit arbiter.
// Default: round-robin scan starting at rr_ptr_i, wrapping at NREQ-1.
// LU_FIXED_PRIO_EN: lowest set index wins, rr_ptr_i is ignored.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  rr_ptr_i,
   output logic [IDW-1:0]  win_o,
   output logic            any_o
);

   // first set request in scan order; found guards against later hits
   always_comb begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      win_o = '0;
      any_o = |req_i;
      for (int k = 0; k < NREQ; k++) begin
`ifdef LU_FIXED_PRIO_EN
         idx = k;
`else
         idx = (int'(rr_ptr_i) + k) % NREQ;
`endif
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win_o = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one registered NOT/AND/OR/XOR unit among NREQ requesters.
// IDLE -> EXEC -> RESP, one operation in flight, 3 cycles per operation.
// Build option LU_FIXED_PRIO_EN selects fixed lowest-index priority.
module logic_unit_arbiter
   import lu_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] a,
   input  logic [WIDTH*NREQ-1:0] b,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data
);

   lu_state_e        state_q;
   logic [IDW-1:0]   rr_ptr_q, ptr_d;
   logic [IDW-1:0]   id_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, res_d;
   logic [NREQ-1:0]  gnt_q;
   logic             busy_q, vld_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [IDW-1:0]   win;
   logic             any;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .win_o    (win),
      .any_o    (any)
   );

   // logic unit on the latched operands
   always_comb begin
      res_d = ~a_q;
      case (op_q)
         OP_NOT:  res_d = ~a_q;
         OP_AND:  res_d = a_q & b_q;
         OP_OR:   res_d = a_q | b_q;
         OP_XOR:  res_d = a_q ^ b_q;
         default: res_d = ~a_q;
      endcase
   end

   // pointer moves just past the last winner, wrapping to 0
   always_comb begin
      ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
   end

   // arbitration FSM with operand latch and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
         vld_q      <= 1'b0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any) begin
                  id_q    <= win;
                  op_q    <= op[2*win +: 2];
                  a_q     <= a[WIDTH*win +: WIDTH];
                  b_q     <= b[WIDTH*win +: WIDTH];
                  gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                  busy_q  <= 1'b1;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_data_q <= res_d;
               rsp_id_q   <= id_q;
               vld_q      <= 1'b1;
               gnt_q      <= '0;
               state_q    <= ST_RESP;
            end
            ST_RESP: begin
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
`ifndef LU_FIXED_PRIO_EN
               rr_ptr_q <= ptr_d;
`endif
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign rsp_valid = vld_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios then random rounds,
// checked against a scan-order / opcode-table reference model.
module tb_logic_unit_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     op;
   logic [WIDTH*NREQ-1:0] a, b;
   logic [NREQ-1:0]       gnt;
   logic                  busy, rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;

   int vectors = 0;
   int miscompares = 0;

   // requester-side view of the operands
   logic [1:0]       m_op [NREQ];
   logic [WIDTH-1:0] m_a  [NREQ];
   logic [WIDTH-1:0] m_b  [NREQ];
   int               m_ptr;

   logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op        (op),
      .a         (a),
      .b         (b),
      .gnt       (gnt),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         op[2*i +: 2]     = m_op[i];
         a[WIDTH*i +: WIDTH] = m_a[i];
         b[WIDTH*i +: WIDTH] = m_b[i];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_lu(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      case (o)
         2'd0:    return ~x;
         2'd1:    return x & y;
         2'd2:    return x | y;
         default: return x ^ y;
      endcase
   endfunction

   function automatic int ref_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
`ifdef LU_FIXED_PRIO_EN
         if (r[k]) return k;
`else
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
      end
      return -1;
   endfunction

   // one full arbitration round from IDLE; req must be nonzero
   task automatic do_round(input bit reraise, input bit scramble, output int w);
      logic [WIDTH-1:0] exp;
      w   = ref_pick(req, m_ptr);
      exp = ref_lu(m_op[w], m_a[w], m_b[w]);
      tick();
      chk("gnt", 32'(gnt), 32'(1 << w));
      chk("busy_exec", 32'(busy), 32'd1);
      chk("vld_exec", 32'(rsp_valid), 32'd0);
      req[w] = 1'b0;
      if (scramble) begin
         m_a[w]  = ~m_a[w];
         m_b[w]  = m_b[w] + 8'd1;
         m_op[w] = m_op[w] + 2'd1;
         apply();
      end
      tick();
      chk("gnt_clr", 32'(gnt), 32'd0);
      chk("vld_resp", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_data", 32'(rsp_data), 32'(exp));
      chk("busy_resp", 32'(busy), 32'd1);
      if (reraise) req[w] = 1'b1;
      tick();
      chk("vld_drop", 32'(rsp_valid), 32'd0);
      chk("busy_drop", 32'(busy), 32'd0);
      chk("data_hold", 32'(rsp_data), 32'(exp));
      m_ptr = (w + 1) % NREQ;
   endtask

   initial begin
      int w;
      int order [5];
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < NREQ; i++) begin
         m_op[i] = 2'd0; m_a[i] = '0; m_b[i] = '0;
      end
      apply();
      m_ptr = 0;

      // reset state
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vld", 32'(rsp_valid), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      rst = 1'b0;

      // reset in the middle of an operation discards it
      m_op[0] = 2'd0; m_a[0] = 8'h0F; apply();
      req = 4'b0001;
      tick();
      chk("mid_gnt", 32'(gnt), 32'd1);
      req = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_gnt0", 32'(gnt), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_vld", 32'(rsp_valid), 32'd0);
      chk("mid_data", 32'(rsp_data), 32'd0);
      tick();
      chk("mid_vld2", 32'(rsp_valid), 32'd0);
      m_ptr = 0;

      // single NOT
      req = 4'b0001;
      do_round(1'b0, 1'b0, w);
      chk("not_data", 32'(rsp_data), 32'hF0);
      tick();
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // all four opcodes from requester 2
      m_a[2] = 8'hCC; m_b[2] = 8'hAA;
      for (int o = 0; o < 4; o++) begin
         logic [WIDTH-1:0] tbl [4];
         tbl[0] = 8'h33; tbl[1] = 8'h88; tbl[2] = 8'hEE; tbl[3] = 8'h66;
         m_op[2] = 2'(o); apply();
         req = 4'b0100;
         do_round(1'b0, 1'b0, w);
         chk("op_tbl", 32'(rsp_data), 32'(tbl[o]));
         chk("op_id", 32'(rsp_id), 32'd2);
      end

      // fairness: all requesting, re-raise one cycle after grant
      rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0;
      for (int i = 0; i < NREQ; i++) begin
         m_op[i] = 2'(i); m_a[i] = 8'(8'h11 * (i + 1)); m_b[i] = 8'(8'h5A ^ i);
      end
      apply();
      req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         do_round(1'b1, 1'b0, w);
         order[r] = w;
      end
`ifndef LU_FIXED_PRIO_EN
      for (int r = 0; r < 5; r++) chk("rr_order", 32'(order[r]), 32'(r % NREQ));
`else
      for (int r = 0; r < 5; r++) chk("fp_order", 32'(order[r]), 32'd0);
`endif

      // contention after wrap: last winner 3, then 1010
      req = 4'b1000;
      tick(); tick(); tick();
      req = 4'b1000;
      do_round(1'b0, 1'b0, w);
      req = 4'b1010;
      do_round(1'b0, 1'b0, w);
      chk("cont_first", 32'(w), 32'd1);
      do_round(1'b0, 1'b0, w);
      chk("cont_second", 32'(w), 32'd3);

      // operand changes after grant must not leak into the result
      m_op[1] = 2'd3; m_a[1] = 8'h3C; m_b[1] = 8'h0F; apply();
      req = 4'b0010;
      do_round(1'b0, 1'b1, w);
      chk("stable", 32'(rsp_data), 32'h33);

      // randomized rounds
      for (int r = 0; r < 60; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 1) == 1) begin
               req[i]  = 1'b1;
               m_op[i] = 2'($urandom_range(0, 3));
               m_a[i]  = 8'($urandom);
               m_b[i]  = 8'($urandom);
            end
         end
         apply();
         if (req == '0) begin
            tick();
            chk("rnd_idle_gnt", 32'(gnt), 32'd0);
            chk("rnd_idle_busy", 32'(busy), 32'd0);
         end else begin
            do_round(1'b0, ($urandom_range(0, 3) == 0), w);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
